// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared controller types, opcode classes and defaults for the memory stage
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_e;

    localparam logic [2:0] LOAD_CLASS_HI3  = 3'b110;
    localparam logic [3:0] LOAD_CLASS_HI4  = 4'b1000;
    localparam logic [2:0] STORE_CLASS_HI3 = 3'b111;
    localparam logic [3:0] STORE_CLASS_HI4 = 4'b1001;

    localparam int TIMEOUT_DEFAULT = 16;

    function automatic logic is_load_op(input logic [6:0] opcode);
        return (opcode[6:4] == LOAD_CLASS_HI3) || (opcode[6:3] == LOAD_CLASS_HI4);
    endfunction

    function automatic logic is_store_op(input logic [6:0] opcode);
        return (opcode[6:4] == STORE_CLASS_HI3) || (opcode[6:3] == STORE_CLASS_HI4);
    endfunction

endpackage

// File: rtl/mem_access_unit_pipeline.sv
// rtl/mem_access_unit_pipeline.sv - memory-stage instruction register and opcode extraction
module memory_pipeline_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic [31:0] instr_in,
    output logic [31:0] instr_q,
    output logic [6:0]  opcode
);

    logic [31:0] instr_d;

    always_comb begin
        instr_d = instr_q;
        if (load_en) begin
            instr_d = instr_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
        end else begin
            instr_q <= instr_d;
        end
    end

    assign opcode = instr_q[6:0];

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory stage controller: load/store handshake with timeout abort
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_in,
    input  logic        valid_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] str_data_in,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        stall,
    output logic [31:0] instr_out,
    output logic        valid_out,
    output logic [31:0] ldr_data_out,
    output logic        mem_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        stall_q, stall_d;
    logic [31:0] instr_out_q, instr_out_d;
    logic        valid_out_q, valid_out_d;
    logic [31:0] ldr_q, ldr_d;
    logic        mem_err_q, mem_err_d;
    logic        accept;
    logic [31:0] cap_instr;
    logic [6:0]  cap_opcode;
    logic [6:0]  in_opcode;

    memory_pipeline_unit u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (accept),
        .instr_in (instr_in),
        .instr_q  (cap_instr),
        .opcode   (cap_opcode)
    );

    assign in_opcode = instr_in[6:0];

    // Outputs are computed for the state being entered so they register alongside it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        stall_d     = 1'b0;
        valid_out_d = 1'b0;
        mem_err_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        instr_out_d = instr_out_q;
        ldr_d       = ldr_q;
        accept      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (valid_in) begin
                    accept      = 1'b1;
                    mem_addr_d  = addr_in;
                    mem_wdata_d = str_data_in;
                    if (is_load_op(in_opcode) || is_store_op(in_opcode)) begin
                        state_d   = ST_ACCESS;
                        cnt_d     = '0;
                        mem_req_d = 1'b1;
                        stall_d   = 1'b1;
                        mem_we_d  = is_store_op(in_opcode);
                    end else begin
                        state_d     = ST_DONE;
                        valid_out_d = 1'b1;
                        instr_out_d = instr_in;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Ack takes priority over the timeout on the final allowed cycle.
                if (mem_ack) begin
                    state_d     = ST_DONE;
                    valid_out_d = 1'b1;
                    instr_out_d = cap_instr;
                    if (is_load_op(cap_opcode)) begin
                        ldr_d = mem_rdata;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = ST_ERR;
                    mem_err_d = 1'b1;
                    stall_d   = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    mem_req_d = 1'b1;
                    stall_d   = 1'b1;
                    mem_we_d  = is_store_op(cap_opcode);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            stall_q     <= 1'b0;
            instr_out_q <= '0;
            valid_out_q <= 1'b0;
            ldr_q       <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            stall_q     <= stall_d;
            instr_out_q <= instr_out_d;
            valid_out_q <= valid_out_d;
            ldr_q       <= ldr_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign stall        = stall_q;
    assign instr_out    = instr_out_q;
    assign valid_out    = valid_out_q;
    assign ldr_data_out = ldr_q;
    assign mem_err      = mem_err_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of ACCESS cycles allowed without mem_ack before an abort.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_in  input  32  instruction arriving from the execute stage.
REQ-005 valid_in  input  1  instr_in is valid this cycle.
REQ-006 addr_in  input  32  effective address computed by the execute stage.
REQ-007 str_data_in  input  32  register data to be stored.
REQ-008 mem_rdata  input  32  read data from data memory, valid when mem_ack=1.
REQ-009 mem_ack  input  1  data memory has completed the current request.
REQ-010 mem_req  output  1  request to data memory.
REQ-011 mem_we  output  1  1 = store, 0 = load; meaningful only while mem_req=1.
REQ-012 mem_addr  output  32  request address.
REQ-013 mem_wdata  output  32  store data.
REQ-014 stall  output  1  upstream must hold instr_in/addr_in/str_data_in/valid_in.
REQ-015 instr_out  output  32  instruction forwarded to the writeback stage.
REQ-016 valid_out  output  1  instr_out/ldr_data_out are valid this cycle.
REQ-017 ldr_data_out  output  32  load data delivered to the writeback stage.
REQ-018 mem_err  output  1  single-cycle pulse marking a timeout abort.

Function
REQ-019 The 7-bit opcode SHALL be decoded from the captured instruction; load class = opcode[6:4]==3'b110 or opcode[6:3]==4'b1000; store class = opcode[6:4]==3'b111 or opcode[6:3]==4'b1001; every other opcode is non-memory.
REQ-020 FSM states: IDLE, ACCESS, DONE, ERR.
REQ-021 Accept: in IDLE or DONE with valid_in=1, the unit SHALL capture instr_in, addr_in and str_data_in on the clock edge.
REQ-022 Transitions after accept:
- load/store -> ACCESS
- non-memory -> DONE
REQ-023 In DONE or IDLE with valid_in=0, the next state SHALL be IDLE.
REQ-024 In ACCESS:
- mem_req=1 and stall=1
- mem_addr/mem_wdata come from the captured values and stay stable
- mem_we=1 for store class only
REQ-025 mem_ack sampled high in ACCESS: go to DONE; for a load, ldr_data_out SHALL take mem_rdata on that same edge.
REQ-026 Minimum load/store latency: 2 edges (accept edge, then ack edge with mem_ack=1 in the first ACCESS cycle); non-memory latency: 1 edge.
REQ-027 In DONE: valid_out=1 for exactly one cycle, instr_out = captured instruction, stall=0; a new instruction can be accepted in the same cycle (back-to-back).
REQ-028 mem_ack outside ACCESS SHALL be ignored.
REQ-029 Timeout: a counter clears on entry to ACCESS and increments each ACCESS cycle without ack; when it reaches TIMEOUT-1 with mem_ack=0, go to ERR.
REQ-030 Simultaneous: if mem_ack=1 in the cycle the counter reaches TIMEOUT-1, the ack wins and the next state is DONE.
REQ-031 In ERR, for one cycle: mem_err=1, valid_out=0, mem_req=0, stall=1; then IDLE.
REQ-032 ldr_data_out SHALL hold its value outside load completion and is unchanged for stores and non-memory instructions.
REQ-033 stall SHALL be 0 in IDLE and DONE.

Reset
REQ-034 Asserting rst_n low SHALL immediately force:
- state=IDLE
- counter=0
- mem_req=0, mem_we=0, mem_err=0, valid_out=0, stall=0
- mem_addr, mem_wdata, instr_out, ldr_data_out = 0
REQ-035 Reset during ACCESS SHALL abandon the request with no valid_out; a late mem_ack after reset is ignored.

Structure
REQ-036 The state enum, the load/store opcode-class constants and the TIMEOUT default SHALL live in the shared controller package.
REQ-037 One sub-module, memory_pipeline_unit, SHALL register the instruction and produce the 7-bit opcode, matching the other per-stage pipeline units.

Verification
REQ-038 Non-memory instruction with valid_in=1: valid_out=1 one edge later; mem_req never asserted.
REQ-039 Load to addr 0x100 with mem_ack two cycles after mem_req and mem_rdata=0xDEADBEEF:
- stall=1 for 2 cycles
- mem_we=0
- then valid_out=1 and ldr_data_out=0xDEADBEEF
REQ-040 Store of 0x12345678 to addr 0x200 with ack in the first ACCESS cycle: mem_we=1, mem_wdata=0x12345678, valid_out one cycle later, ldr_data_out unchanged.
REQ-041 Load with no ack and TIMEOUT=16: mem_req high for 16 cycles, then mem_err pulses 1 cycle, valid_out stays 0, then IDLE.
REQ-042 Back-to-back load then non-memory instruction, with the second held during stall: the second is accepted in the DONE cycle and its valid_out follows one edge later.
REQ-043 rst_n low mid-ACCESS, then a late mem_ack: all outputs 0 immediately and no valid_out results.
